pc_sequencer: RTL and testbench

//   Next-address controller for the ProgramCounter register (Address in, PCResult out).

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_sequencer_target_mux.sv | 30 +++
 rtl/pc_sequencer.sv | 117 +++++++++++
 tb/tb_pc_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC next-address controller: state encoding, vectors, PC step.
// No logic, no latency, no backpressure.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0080;
  localparam logic [31:0] PC_STEP          = 32'd4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pc_sequencer_target_mux.sv
// Selects the redirect target by priority (JR > J > branch) and flags misaligned targets.
// Purely combinational, zero latency; no backpressure.
// Stateless; the caller decides whether a redirect is honoured in the current state.
module pc_target_mux
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        redirect,
  output logic [31:0] target,
  output logic        misaligned
);

  always_comb begin
    redirect = jump_reg | jump | branch_taken;
    target   = branch_target;
    if (jump_reg) begin
      target = reg_target;
    end else if (jump) begin
      target = {pc_plus4[31:28], jump_index, 2'b00};
    end
    misaligned = redirect && (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: sequential/branch/jump/JR/hold selection, post-redirect IF flush, misalign trap, halt.
// Address and PCPlus4 are zero-latency; flags, EPC and count update on the next Clk edge.
// No backpressure: Stall holds the PC; redirects are always accepted in RUN and dropped otherwise.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCResult,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  input  logic        JumpReg,
  input  logic [31:0] RegTarget,
  input  logic        Halt,
  output logic [31:0] Address,
  output logic [31:0] PCPlus4,
  output logic        IFFlush,
  output logic        Exception,
  output logic [31:0] EPC,
  output logic        Halted,
  output logic [15:0] RedirectCount
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  seq_state_t  cur_state;
  logic [1:0]  flush_cnt;
  logic [15:0] redirect_cnt;
  logic        redirect;
  logic        misaligned;
  logic [31:0] target;

  assign PCPlus4       = PCResult + PC_STEP;
  assign RedirectCount = redirect_cnt;

  pc_target_mux u_target_mux (
    .pc_plus4      (PCPlus4),
    .jump_reg      (JumpReg),
    .reg_target    (RegTarget),
    .jump          (Jump),
    .jump_index    (JumpIndex),
    .branch_taken  (BranchTaken),
    .branch_target (BranchTarget),
    .redirect      (redirect),
    .target        (target),
    .misaligned    (misaligned)
  );

  always_comb begin
    Address = PCPlus4;
    if (Reset) begin
      Address = RESET_VECTOR;
    end else begin
      case (cur_state)
        RUN: begin
          if (redirect)   Address = misaligned ? EXC_VECTOR : target;
          else if (Halt)  Address = PCResult;
          else if (Stall) Address = PCResult;
          else            Address = PCPlus4;
        end
        FLUSH:   Address = PCPlus4;
        HALTED:  Address = PCResult;
        default: Address = PCPlus4;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cur_state    <= RUN;
      flush_cnt    <= 2'd0;
      IFFlush      <= 1'b0;
      Exception    <= 1'b0;
      EPC          <= 32'h0;
      Halted       <= 1'b0;
      redirect_cnt <= 16'h0;
    end else begin
      Exception <= 1'b0;
      case (cur_state)
        RUN: begin
          if (redirect) begin
            cur_state    <= FLUSH;
            IFFlush      <= 1'b1;
            flush_cnt    <= FLUSH_LOAD;
            redirect_cnt <= sat_inc16(redirect_cnt);
            if (misaligned) begin
              EPC       <= PCResult;
              Exception <= 1'b1;
            end
          end else if (Halt) begin
            cur_state <= HALTED;
            Halted    <= 1'b1;
          end
        end
        // Wrong-path instructions are being squashed here, so their control inputs are ignored.
        FLUSH: begin
          if (flush_cnt == 2'd0) begin
            cur_state <= RUN;
            IFFlush   <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 2'd1;
          end
        end
        HALTED: Halted <= 1'b1;
        default: cur_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer closed around a ProgramCounter register model; expected PCs flow through a queue.
// One task per scenario, each comparing inline against bench-derived values.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] pc;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        Jump = 1'b0;
  logic [25:0] JumpIndex = 26'h0;
  logic        JumpReg = 1'b0;
  logic [31:0] RegTarget = 32'h0;
  logic        Halt = 1'b0;
  logic [31:0] Address;
  logic [31:0] PCPlus4;
  logic        IFFlush;
  logic        Exception;
  logic [31:0] EPC;
  logic        Halted;
  logic [15:0] RedirectCount;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .PCResult(pc), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpIndex(JumpIndex), .JumpReg(JumpReg), .RegTarget(RegTarget),
    .Halt(Halt), .Address(Address), .PCPlus4(PCPlus4), .IFFlush(IFFlush),
    .Exception(Exception), .EPC(EPC), .Halted(Halted), .RedirectCount(RedirectCount)
  );

  always #10 Clk = ~Clk;

  // ProgramCounter: plain register loading Address every edge.
  always @(posedge Clk) pc <= Address;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    Stall = 0; BranchTaken = 0; BranchTarget = 0; Jump = 0; JumpIndex = 0;
    JumpReg = 0; RegTarget = 0; Halt = 0;
  endtask

  task automatic test_reset();
    Reset = 1; clear_inputs();
    tick(); tick();
    tests_run++; if (Address !== 32'h0) begin tests_failed++; $display("FAIL reset_addr got=%h exp=%h", Address, 32'h0); end
    tests_run++; if (pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    tests_run++; if ({IFFlush, Exception, Halted} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got=%b exp=000", {IFFlush, Exception, Halted}); end
    tests_run++; if (EPC !== 32'h0) begin tests_failed++; $display("FAIL reset_epc got=%h exp=0", EPC); end
    tests_run++; if (RedirectCount !== 16'h0) begin tests_failed++; $display("FAIL reset_cnt got=%h exp=0", RedirectCount); end
    Reset = 0;
  endtask

  task automatic test_sequential_stall();
    bit          st [7] = '{0, 0, 1, 1, 1, 0, 0};
    logic [31:0] ex [7] = '{32'd4, 32'd8, 32'd8, 32'd8, 32'd8, 32'd12, 32'd16};
    logic [31:0] e;
    for (int i = 0; i < 7; i++) begin
      Stall = st[i];
      exp_q.push_back(ex[i]);
      tick();
      e = exp_q.pop_front();
      tests_run++; if (pc !== e) begin tests_failed++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc, e); end
      tests_run++; if (IFFlush !== 1'b0) begin tests_failed++; $display("FAIL seq_flush[%0d] got=%b exp=0", i, IFFlush); end
    end
    Stall = 0;
  endtask

  task automatic test_branch_over_stall();
    logic [31:0] e;
    BranchTaken = 1; BranchTarget = 32'h40; Stall = 1;
    exp_q.push_back(32'h40);
    tick(); clear_inputs();
    e = exp_q.pop_front();
    tests_run++; if (pc !== e) begin tests_failed++; $display("FAIL br_pc got=%h exp=%h", pc, e); end
    tests_run++; if (IFFlush !== 1'b1) begin tests_failed++; $display("FAIL br_flush got=%b exp=1", IFFlush); end
    tests_run++; if (RedirectCount !== 16'd1) begin tests_failed++; $display("FAIL br_cnt got=%0d exp=1", RedirectCount); end
    // wrong-path redirect, halt and stall during the flush cycle
    BranchTaken = 1; BranchTarget = 32'h200; Jump = 1; JumpIndex = 26'h99; Halt = 1; Stall = 1;
    exp_q.push_back(32'h44);
    tick(); clear_inputs();
    e = exp_q.pop_front();
    tests_run++; if (pc !== e) begin tests_failed++; $display("FAIL flush_ign_pc got=%h exp=%h", pc, e); end
    tests_run++; if (IFFlush !== 1'b0) begin tests_failed++; $display("FAIL flush_end got=%b exp=0", IFFlush); end
    tests_run++; if ({Halted, RedirectCount} !== {1'b0, 16'd1}) begin tests_failed++; $display("FAIL flush_ign_state got=%b/%0d exp=0/1", Halted, RedirectCount); end
  endtask

  task automatic test_jump_and_trap();
    logic [31:0] e;
    Jump = 1; JumpIndex = 26'h10;
    exp_q.push_back(32'h40);
    tick(); clear_inputs();
    e = exp_q.pop_front();
    tests_run++; if (pc !== e) begin tests_failed++; $display("FAIL j_pc got=%h exp=%h", pc, e); end
    tests_run++; if ({IFFlush, RedirectCount} !== {1'b1, 16'd2}) begin tests_failed++; $display("FAIL j_state got=%b/%0d exp=1/2", IFFlush, RedirectCount); end
    exp_q.push_back(32'h44);
    tick();
    e = exp_q.pop_front();
    tests_run++; if (pc !== e) begin tests_failed++; $display("FAIL j_flush_pc got=%h exp=%h", pc, e); end
    JumpReg = 1; RegTarget = 32'h102;
    exp_q.push_back(32'h80);
    tick(); clear_inputs();
    e = exp_q.pop_front();
    tests_run++; if (pc !== e) begin tests_failed++; $display("FAIL jr_trap_pc got=%h exp=%h", pc, e); end
    tests_run++; if (Exception !== 1'b1) begin tests_failed++; $display("FAIL jr_exc got=%b exp=1", Exception); end
    tests_run++; if (EPC !== 32'h44) begin tests_failed++; $display("FAIL jr_epc got=%h exp=%h", EPC, 32'h44); end
    tests_run++; if (RedirectCount !== 16'd3) begin tests_failed++; $display("FAIL jr_cnt got=%0d exp=3", RedirectCount); end
    exp_q.push_back(32'h84);
    tick();
    e = exp_q.pop_front();
    tests_run++; if (pc !== e) begin tests_failed++; $display("FAIL trap_flush_pc got=%h exp=%h", pc, e); end
    tests_run++; if ({Exception, IFFlush} !== 2'b00) begin tests_failed++; $display("FAIL exc_pulse got=%b exp=00", {Exception, IFFlush}); end
  endtask

  task automatic test_priority();
    logic [31:0] e;
    JumpReg = 1; RegTarget = 32'h100; Jump = 1; JumpIndex = 26'h20; BranchTaken = 1; BranchTarget = 32'h300;
    exp_q.push_back(32'h100);
    tick(); clear_inputs();
    e = exp_q.pop_front();
    tests_run++; if (pc !== e) begin tests_failed++; $display("FAIL prio_jr got=%h exp=%h", pc, e); end
    exp_q.push_back(32'h104);
    tick();
    e = exp_q.pop_front();
    tests_run++; if (pc !== e) begin tests_failed++; $display("FAIL prio_jr_flush got=%h exp=%h", pc, e); end
    Jump = 1; JumpIndex = 26'h50; BranchTaken = 1; BranchTarget = 32'h300; Halt = 1;
    exp_q.push_back(32'h140);
    tick(); clear_inputs();
    e = exp_q.pop_front();
    tests_run++; if (pc !== e) begin tests_failed++; $display("FAIL prio_j got=%h exp=%h", pc, e); end
    tests_run++; if (Halted !== 1'b0) begin tests_failed++; $display("FAIL prio_j_halt got=%b exp=0", Halted); end
    exp_q.push_back(32'h144);
    tick();
    e = exp_q.pop_front();
    tests_run++; if (pc !== e) begin tests_failed++; $display("FAIL prio_j_flush got=%h exp=%h", pc, e); end
    BranchTaken = 1; BranchTarget = 32'h302;
    exp_q.push_back(32'h80);
    tick(); clear_inputs();
    e = exp_q.pop_front();
    tests_run++; if (pc !== e) begin tests_failed++; $display("FAIL br_trap_pc got=%h exp=%h", pc, e); end
    tests_run++; if ({Exception, EPC, RedirectCount} !== {1'b1, 32'h144, 16'd6}) begin tests_failed++; $display("FAIL br_trap_state got=%b/%h/%0d exp=1/144/6", Exception, EPC, RedirectCount); end
    exp_q.push_back(32'h84);
    tick();
    e = exp_q.pop_front();
    tests_run++; if (pc !== e) begin tests_failed++; $display("FAIL br_trap_flush got=%h exp=%h", pc, e); end
  endtask

  task automatic test_halt();
    logic [31:0] e;
    Jump = 1; JumpIndex = 26'h8;
    exp_q.push_back(32'h20);
    tick(); clear_inputs();
    exp_q.push_back(32'h24);
    tick();
    void'(exp_q.pop_front());
    e = exp_q.pop_front();
    tests_run++; if (pc !== e) begin tests_failed++; $display("FAIL halt_setup got=%h exp=%h", pc, e); end
    Halt = 1; Stall = 1;
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(32'h24);
      tick();
      e = exp_q.pop_front();
      tests_run++; if ({pc, Halted} !== {e, 1'b1}) begin tests_failed++; $display("FAIL halted[%0d] got=%h/%b exp=%h/1", i, pc, Halted, e); end
      Halt = 1'($urandom); Stall = 1'($urandom); BranchTaken = 1;
      BranchTarget = $urandom & 32'hFFFF_FFFC; Jump = 1'($urandom); JumpReg = 1'($urandom); RegTarget = $urandom;
    end
    tests_run++; if ({RedirectCount, IFFlush} !== {16'd7, 1'b0}) begin tests_failed++; $display("FAIL halted_state got=%0d/%b exp=7/0", RedirectCount, IFFlush); end
    clear_inputs(); Reset = 1;
    exp_q.push_back(32'h0);
    tick();
    e = exp_q.pop_front();
    tests_run++; if ({pc, Halted, RedirectCount} !== {e, 1'b0, 16'd0}) begin tests_failed++; $display("FAIL halt_reset got=%h/%b/%0d exp=%h/0/0", pc, Halted, RedirectCount, e); end
    Reset = 0;
  endtask

  task automatic test_reset_mid_flush();
    logic [31:0] e;
    BranchTaken = 1; BranchTarget = 32'h40;
    exp_q.push_back(32'h40);
    tick(); clear_inputs();
    e = exp_q.pop_front();
    tests_run++; if ({pc, IFFlush} !== {e, 1'b1}) begin tests_failed++; $display("FAIL mf_redirect got=%h/%b exp=%h/1", pc, IFFlush, e); end
    Reset = 1;
    exp_q.push_back(32'h0);
    tick(); Reset = 0;
    e = exp_q.pop_front();
    tests_run++; if ({pc, IFFlush, RedirectCount} !== {e, 1'b0, 16'd0}) begin tests_failed++; $display("FAIL mf_reset got=%h/%b/%0d exp=%h/0/0", pc, IFFlush, RedirectCount, e); end
    exp_q.push_back(32'h4);
    tick();
    Stall = 1;
    exp_q.push_back(32'h4);
    tick(); Stall = 0;
    void'(exp_q.pop_front());
    e = exp_q.pop_front();
    tests_run++; if (pc !== e) begin tests_failed++; $display("FAIL mf_run_stall got=%h exp=%h", pc, e); end
  endtask

  task automatic test_saturation_and_wrap();
    logic [31:0] e;
    force dut.redirect_cnt = 16'hFFFE;
    #1 release dut.redirect_cnt;
    BranchTaken = 1; BranchTarget = 32'h100;
    tick(); clear_inputs();
    tests_run++; if (RedirectCount !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_step got=%h exp=FFFF", RedirectCount); end
    tick();
    JumpReg = 1; RegTarget = 32'hFFFF_FFFC;
    exp_q.push_back(32'hFFFF_FFFC);
    tick(); clear_inputs();
    e = exp_q.pop_front();
    tests_run++; if (RedirectCount !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_hold got=%h exp=FFFF", RedirectCount); end
    tests_run++; if (pc !== e) begin tests_failed++; $display("FAIL wrap_setup got=%h exp=%h", pc, e); end
    tests_run++; if (PCPlus4 !== 32'h0) begin tests_failed++; $display("FAIL wrap_plus4 got=%h exp=0", PCPlus4); end
    exp_q.push_back(32'h0);
    tick();
    e = exp_q.pop_front();
    tests_run++; if (pc !== e) begin tests_failed++; $display("FAIL wrap_pc got=%h exp=%h", pc, e); end
    JumpReg = 1; RegTarget = 32'h3000_0000;
    tick(); clear_inputs();
    tick();
    Jump = 1; JumpIndex = 26'h4;
    exp_q.push_back(32'h3000_0010);
    tick(); clear_inputs();
    e = exp_q.pop_front();
    tests_run++; if (pc !== e) begin tests_failed++; $display("FAIL j_upper got=%h exp=%h", pc, e); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential_stall();
    test_branch_over_stall();
    test_jump_and_trap();
    test_priority();
    test_halt();
    test_reset_mid_flush();
    test_saturation_and_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
